// File: rtl/ctrl_pkg.sv
// Shared constants for the accumulator-machine sequencer: opcodes, T-state
// encodings and the run/halt mode of the controller.
package ctrl_pkg;

    localparam int unsigned NT = 6;

    typedef enum logic [3:0] {
        OP_LDA = 4'b0000,
        OP_ADD = 4'b0001,
        OP_SUB = 4'b0010,
        OP_OUT = 4'b1110,
        OP_HLT = 4'b1111
    } opcode_t;

    localparam logic [NT-1:0] T1 = 6'b000001;
    localparam logic [NT-1:0] T2 = 6'b000010;
    localparam logic [NT-1:0] T3 = 6'b000100;
    localparam logic [NT-1:0] T4 = 6'b001000;
    localparam logic [NT-1:0] T5 = 6'b010000;
    localparam logic [NT-1:0] T6 = 6'b100000;

    typedef enum logic {
        MODE_RUN  = 1'b0,
        MODE_HALT = 1'b1
    } mode_t;

endpackage

// File: rtl/ring_counter.sv
// One-hot T-state ring counter: reset loads T1, clear empties the ring,
// enable rotates one position per clock.
module ring_counter
    import ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clr,
    output logic [NT-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst)
            q <= T1;
        else if (clr)
            q <= '0;
        else if (en)
            q <= {q[NT-2:0], q[NT-1]};
    end

endmodule

// File: rtl/acc_seq_ctrl.sv
// Fixed six-cycle instruction sequencer for a bus-based accumulator machine:
// fetch in T1..T3, opcode-dependent execute in T4..T6, sticky halt on HLT.
module acc_seq_ctrl
    import ctrl_pkg::*;
#(
    parameter int unsigned OPW = 4
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           RUN,
    input  logic [OPW-1:0] IR_OP,
    output logic           CP,
    output logic           EP,
    output logic           LM,
    output logic           CE,
    output logic           LI,
    output logic           EI,
    output logic           IA,
    output logic           EA,
    output logic           SU,
    output logic           EU,
    output logic           IB,
    output logic           LO,
    output logic           HALT,
    output logic [5:0]     T_STATE
);

    mode_t mode_q, mode_d;
    logic  halt_hit;
    logic  active;
    logic  is_lda, is_add, is_sub, is_out, is_hlt;

    assign is_lda = (IR_OP == OPW'(OP_LDA));
    assign is_add = (IR_OP == OPW'(OP_ADD));
    assign is_sub = (IR_OP == OPW'(OP_SUB));
    assign is_out = (IR_OP == OPW'(OP_OUT));
    assign is_hlt = (IR_OP == OPW'(OP_HLT));

    // HLT takes effect on the edge that would have left T4; the same edge clears the ring.
    assign halt_hit = (mode_q == MODE_RUN) && RUN && (T_STATE == T4) && is_hlt;
    assign active   = !RST && RUN && (mode_q == MODE_RUN);
    assign HALT     = (mode_q == MODE_HALT);

    ring_counter u_ring (
        .clk (CLK),
        .rst (RST),
        .en  (RUN && (mode_q == MODE_RUN)),
        .clr (halt_hit),
        .q   (T_STATE)
    );

    always_ff @(posedge CLK) begin
        if (RST)
            mode_q <= MODE_RUN;
        else
            mode_q <= mode_d;
    end

    always_comb begin
        mode_d = mode_q;
        if (halt_hit)
            mode_d = MODE_HALT;
    end

    always_comb begin
        {CP, EP, LM, CE, LI, EI, IA, EA, SU, EU, IB, LO} = '0;
        if (active) begin
            case (T_STATE)
                T1: begin EP = 1'b1; LM = 1'b1; end
                T2: CP = 1'b1;
                T3: begin CE = 1'b1; LI = 1'b1; end
                T4: begin
                    if (is_lda || is_add || is_sub) begin EI = 1'b1; LM = 1'b1; end
                    if (is_out) begin EA = 1'b1; LO = 1'b1; end
                end
                T5: begin
                    if (is_lda) begin CE = 1'b1; IA = 1'b1; end
                    if (is_add || is_sub) begin CE = 1'b1; IB = 1'b1; end
                end
                T6: begin
                    if (is_add || is_sub) begin EU = 1'b1; IA = 1'b1; end
                    if (is_sub) SU = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_acc_seq_ctrl.sv
// Self-checking bench for acc_seq_ctrl against an instruction-step reference model.
module tb_acc_seq_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       RUN = 1'b1;
    logic [3:0] IR_OP = '0;
    logic CP, EP, LM, CE, LI, EI, IA, EA, SU, EU, IB, LO, HALT;
    logic [5:0] T_STATE;

    int vectors = 0;
    int miscompares = 0;

    // model state: step number 1..6 within the instruction, halted flag
    int m_step  = 1;
    bit m_halt  = 1'b0;
    bit m_known = 1'b0;

    localparam int B_CP = 11, B_EP = 10, B_LM = 9, B_CE = 8, B_LI = 7, B_EI = 6;
    localparam int B_IA = 5,  B_EA = 4,  B_SU = 3, B_EU = 2, B_IB = 1, B_LO = 0;

    acc_seq_ctrl #(.OPW(4)) dut (
        .CLK(CLK), .RST(RST), .RUN(RUN), .IR_OP(IR_OP),
        .CP(CP), .EP(EP), .LM(LM), .CE(CE), .LI(LI), .EI(EI),
        .IA(IA), .EA(EA), .SU(SU), .EU(EU), .IB(IB), .LO(LO),
        .HALT(HALT), .T_STATE(T_STATE)
    );

    always #5 CLK = ~CLK;

    function automatic logic [11:0] model_ctrl(input int s, input logic [3:0] op);
        logic [11:0] v;
        v = '0;
        case (s)
            1: begin v[B_EP] = 1'b1; v[B_LM] = 1'b1; end
            2: v[B_CP] = 1'b1;
            3: begin v[B_CE] = 1'b1; v[B_LI] = 1'b1; end
            4: begin
                if (op == 4'd0 || op == 4'd1 || op == 4'd2) begin v[B_EI] = 1'b1; v[B_LM] = 1'b1; end
                if (op == 4'd14) begin v[B_EA] = 1'b1; v[B_LO] = 1'b1; end
            end
            5: begin
                if (op == 4'd0) begin v[B_CE] = 1'b1; v[B_IA] = 1'b1; end
                if (op == 4'd1 || op == 4'd2) begin v[B_CE] = 1'b1; v[B_IB] = 1'b1; end
            end
            6: begin
                if (op == 4'd1 || op == 4'd2) begin v[B_EU] = 1'b1; v[B_IA] = 1'b1; end
                if (op == 4'd2) v[B_SU] = 1'b1;
            end
            default: ;
        endcase
        return v;
    endfunction

    task automatic step(input bit r, input bit ru, input logic [3:0] op);
        logic [11:0] act, exp;
        logic [5:0]  exp_t;
        RST = r; RUN = ru; IR_OP = op;
        @(negedge CLK);
        act = {CP, EP, LM, CE, LI, EI, IA, EA, SU, EU, IB, LO};
        exp = (r || !ru || m_halt || !m_known) ? 12'd0 : model_ctrl(m_step, op);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL ctrl t=%0t step=%0d op=%b act=%b exp=%b", $time, m_step, op, act, exp);
        end
        if (m_known) begin
            exp_t = m_halt ? 6'd0 : (6'd1 << (m_step - 1));
            vectors++;
            if (T_STATE !== exp_t) begin
                miscompares++;
                $display("FAIL t_state t=%0t act=%b exp=%b", $time, T_STATE, exp_t);
            end
            vectors++;
            if (HALT !== m_halt) begin
                miscompares++;
                $display("FAIL halt t=%0t act=%b exp=%b", $time, HALT, m_halt);
            end
        end
        vectors++;
        assert ($countones({EP, CE, EI, EA, EU}) <= 1) else begin
            miscompares++;
            $display("FAIL bus_driver t=%0t drivers=%b required=at most one", $time, {EP, CE, EI, EA, EU});
        end
        @(posedge CLK);
        if (r) begin
            m_step = 1; m_halt = 1'b0; m_known = 1'b1;
        end else if (!m_halt && ru) begin
            if (m_step == 4 && op == 4'hF) m_halt = 1'b1;
            else m_step = (m_step % 6) + 1;
        end
        #1;
    endtask

    function automatic logic [3:0] rnd_op();
        return 4'($urandom_range(15, 0));
    endfunction

    task automatic run_instr(input logic [3:0] op);
        for (int i = 1; i <= 6; i++)
            step(1'b0, 1'b1, (i <= 3) ? rnd_op() : op);
    endtask

    task automatic test_reset();
        step(1'b1, 1'b1, rnd_op());
        step(1'b1, 1'b1, rnd_op());
        step(1'b0, 1'b1, rnd_op());
    endtask

    task automatic test_add();
        step(1'b1, 1'b0, 4'd0);
        run_instr(4'b0001);
        step(1'b0, 1'b1, rnd_op());
    endtask

    task automatic test_sub_out();
        step(1'b1, 1'b0, 4'd0);
        run_instr(4'b0010);
        run_instr(4'b1110);
        run_instr(4'b0000);
        run_instr(4'b0101);
        step(1'b0, 1'b1, rnd_op());
    endtask

    task automatic test_freeze();
        step(1'b1, 1'b1, 4'd0);
        step(1'b0, 1'b1, rnd_op());
        step(1'b0, 1'b1, rnd_op());
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, rnd_op());
        step(1'b0, 1'b1, rnd_op());
        step(1'b0, 1'b1, 4'b0001);
        step(1'b0, 1'b1, 4'b0001);
        step(1'b0, 1'b1, 4'b0001);
        step(1'b0, 1'b1, rnd_op());
    endtask

    task automatic test_halt();
        step(1'b1, 1'b1, 4'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, rnd_op());
        step(1'b0, 1'b1, 4'hF);
        for (int i = 0; i < 10; i++) step(1'b0, 1'($urandom_range(1, 0)), rnd_op());
        step(1'b1, 1'b1, rnd_op());
        step(1'b0, 1'b1, rnd_op());
    endtask

    task automatic test_random();
        int halted_for;
        bit r;
        halted_for = 0;
        for (int i = 0; i < 2000; i++) begin
            halted_for = m_halt ? halted_for + 1 : 0;
            r = (halted_for > 4) || ($urandom_range(99, 0) == 0);
            step(r, ($urandom_range(3, 0) != 0), rnd_op());
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_out();
        test_freeze();
        test_halt();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
